// File: rtl/gmii_tx_framer_if.sv
// Byte-stream sink and GMII transmit pins of the framer.
// Signal suffixes are named from the framer's side of the bundle.
interface gmii_tx_framer_if;
  logic [7:0] snk_data_i;
  logic       snk_valid_i;
  logic       snk_sop_i;
  logic       snk_eop_i;
  logic       snk_err_i;
  logic       snk_ready_o;
  logic       gmii_tx_en_o;
  logic [7:0] gmii_tx_d_o;
  logic       gmii_tx_err_o;
  logic       frame_done_o;
  logic       frame_err_o;

  modport slave (
    input  snk_data_i, snk_valid_i, snk_sop_i, snk_eop_i, snk_err_i,
    output snk_ready_o, gmii_tx_en_o, gmii_tx_d_o, gmii_tx_err_o,
           frame_done_o, frame_err_o
  );

  modport master (
    output snk_data_i, snk_valid_i, snk_sop_i, snk_eop_i, snk_err_i,
    input  snk_ready_o, gmii_tx_en_o, gmii_tx_d_o, gmii_tx_err_o,
           frame_done_o, frame_err_o
  );
endinterface

// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: preamble/SFD insertion, zero padding, FCS append,
// inter-frame gap. One byte per clock; all pin outputs are registered.
module gmii_tx_framer #(
  parameter int MIN_FRAME_LEN = 60,
  parameter int IFG_BYTES     = 12,
  parameter int PREAMBLE_LEN  = 7
) (
  input  logic             clk_i,
  input  logic             rst_i,
  gmii_tx_framer_if.slave  bus
);

  localparam int LEN_W   = (MIN_FRAME_LEN > 0) ? $clog2(MIN_FRAME_LEN + 1) : 1;
  localparam int CNT_MX0 = (PREAMBLE_LEN > IFG_BYTES) ? PREAMBLE_LEN : IFG_BYTES;
  localparam int CNT_MAX = (CNT_MX0 > 4) ? CNT_MX0 : 4;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PREAMBLE_LEN - 1);
  localparam logic [CNT_W-1:0] FCS_LAST = CNT_W'(3);
  // The pins already spend one idle cycle in IDLE and one while the first
  // preamble byte is being registered, so IFG itself lasts IFG_BYTES-1 cycles.
  localparam logic [CNT_W-1:0] IFG_LAST = CNT_W'((IFG_BYTES > 2) ? IFG_BYTES - 2 : 0);
  localparam logic [LEN_W-1:0] MIN_LEN  = LEN_W'(MIN_FRAME_LEN);

  typedef enum logic [2:0] {
    S_IDLE, S_PREAMBLE, S_SFD, S_DATA, S_PAD, S_FCS, S_ABORT, S_IFG
  } state_t;

  // Byte-wise update of the reflected CRC-32.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d, len_inc;
  logic [31:0]      crc_q, crc_d;
  logic             tx_en_q, tx_en_d;
  logic [7:0]       tx_d_q, tx_d_d;
  logic             tx_err_q, tx_err_d;
  logic             done_q, done_d;
  logic             ferr_q, ferr_d;
  logic             ready;

  assign len_inc = (len_q == '1) ? len_q : len_q + 1'b1;

  // Next state, pin values for the following cycle, CRC and length tracking.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    len_d    = len_q;
    crc_d    = crc_q;
    tx_en_d  = 1'b0;
    tx_d_d   = 8'h00;
    tx_err_d = 1'b0;
    done_d   = 1'b0;
    ferr_d   = 1'b0;
    ready    = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Stray non-sop bytes are swallowed; the sop byte waits for DATA.
        ready = bus.snk_valid_i && !bus.snk_sop_i;
        len_d = '0;
        crc_d = '1;
        if (bus.snk_valid_i && bus.snk_sop_i) state_d = S_PREAMBLE;
      end
      S_PREAMBLE: begin
        tx_en_d = 1'b1;
        tx_d_d  = 8'h55;
        if (cnt_q == PRE_LAST) state_d = S_SFD;
      end
      S_SFD: begin
        tx_en_d = 1'b1;
        tx_d_d  = 8'hD5;
        state_d = S_DATA;
      end
      S_DATA: begin
        ready   = 1'b1;
        tx_en_d = 1'b1;
        if (!bus.snk_valid_i) begin
          tx_err_d = 1'b1;
          ferr_d   = 1'b1;
          state_d  = S_ABORT;
        end else if (bus.snk_err_i) begin
          tx_err_d = 1'b1;
          ferr_d   = 1'b1;
          state_d  = bus.snk_eop_i ? S_IFG : S_ABORT;
        end else begin
          tx_d_d = bus.snk_data_i;
          crc_d  = crc_byte(crc_q, bus.snk_data_i);
          len_d  = len_inc;
          if (bus.snk_eop_i) state_d = (len_inc < MIN_LEN) ? S_PAD : S_FCS;
        end
      end
      S_PAD: begin
        tx_en_d = 1'b1;
        crc_d   = crc_byte(crc_q, 8'h00);
        len_d   = len_inc;
        if (len_inc >= MIN_LEN) state_d = S_FCS;
      end
      S_FCS: begin
        // Shift the finished CRC out LSB first; it is re-seeded in IDLE.
        tx_en_d = 1'b1;
        tx_d_d  = ~crc_q[7:0];
        crc_d   = {8'hFF, crc_q[31:8]};
        if (cnt_q == FCS_LAST) begin
          done_d  = 1'b1;
          state_d = S_IFG;
        end
      end
      S_ABORT: begin
        ready = 1'b1;
        if (bus.snk_valid_i && bus.snk_eop_i) state_d = S_IFG;
      end
      S_IFG: begin
        if (cnt_q == IFG_LAST) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  // State and registered pins; reset drops the pins idle on the next edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      len_q    <= '0;
      crc_q    <= '1;
      tx_en_q  <= 1'b0;
      tx_d_q   <= 8'h00;
      tx_err_q <= 1'b0;
      done_q   <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      crc_q    <= crc_d;
      tx_en_q  <= tx_en_d;
      tx_d_q   <= tx_d_d;
      tx_err_q <= tx_err_d;
      done_q   <= done_d;
      ferr_q   <= ferr_d;
    end
  end

  assign bus.snk_ready_o   = ready;
  assign bus.gmii_tx_en_o  = tx_en_q;
  assign bus.gmii_tx_d_o   = tx_d_q;
  assign bus.gmii_tx_err_o = tx_err_q;
  assign bus.frame_done_o  = done_q;
  assign bus.frame_err_o   = ferr_q;

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Scoreboard bench for gmii_tx_framer: expected pin cycles are queued when a
// frame is issued and popped by a pin monitor. A second instance with padding
// disabled checks the known "123456789" FCS.
module tb_gmii_tx_framer;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [7:0] d;
    logic       err;
    logic       done;
    logic       ferr;
    logic [1:0] gap;
  } exp_t;

  localparam logic [1:0] G_MIN = 2'd0, G_EXACT = 2'd1, G_NONE = 2'd2;
  localparam int IFG = 12;
  localparam int MINLEN = 60;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #4 clk = ~clk;

  gmii_tx_framer_if bus ();
  gmii_tx_framer_if busk ();

  gmii_tx_framer dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  gmii_tx_framer #(.MIN_FRAME_LEN(0)) dutk (.clk_i(clk), .rst_i(rst), .bus(busk));

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  // CRC-32 in the MSB-first formulation: feed bits LSB first, reflect, invert.
  function automatic logic [31:0] ref_fcs(input bq_t msg);
    logic [31:0] r;
    logic [31:0] o;
    logic        fb;
    r = '1;
    foreach (msg[k])
      for (int i = 0; i < 8; i++) begin
        fb = r[31] ^ msg[k][i];
        r  = r << 1;
        if (fb) r = r ^ 32'h04C11DB7;
      end
    for (int i = 0; i < 32; i++) o[i] = r[31-i];
    return ~o;
  endfunction

  function automatic bq_t rnd_payload(input int n);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(255)));
    return q;
  endfunction

  task automatic push_rec(input logic [7:0] d, input logic er, input logic dn,
                          input logic fe, input logic [1:0] g);
    exp_t e;
    e = '{d: d, err: er, done: dn, ferr: fe, gap: g};
    sb.push_back(e);
  endtask

  // Expected pin cycles for one frame. stop_at: bytes shown before the error
  // cycle; reset_at: bytes shown before reset kills the frame.
  task automatic push_frame(input bq_t pl, input int stop_at, input int reset_at,
                            input logic [1:0] g);
    bq_t         msg;
    logic [31:0] fcs;
    push_rec(8'h55, 1'b0, 1'b0, 1'b0, g);
    for (int i = 1; i < 7; i++) push_rec(8'h55, 1'b0, 1'b0, 1'b0, G_NONE);
    push_rec(8'hD5, 1'b0, 1'b0, 1'b0, G_NONE);
    if (reset_at >= 0) begin
      for (int k = 0; k < reset_at; k++) push_rec(pl[k], 1'b0, 1'b0, 1'b0, G_NONE);
    end else if (stop_at >= 0) begin
      for (int k = 0; k < stop_at; k++) push_rec(pl[k], 1'b0, 1'b0, 1'b0, G_NONE);
      push_rec(8'h00, 1'b1, 1'b0, 1'b1, G_NONE);
    end else begin
      msg = pl;
      while (msg.size() < MINLEN) msg.push_back(8'h00);
      foreach (msg[k]) push_rec(msg[k], 1'b0, 1'b0, 1'b0, G_NONE);
      fcs = ref_fcs(msg);
      for (int i = 0; i < 4; i++) push_rec(fcs[8*i +: 8], 1'b0, (i == 3), 1'b0, G_NONE);
    end
  endtask

  // Present one byte and hold it until the DUT takes it (bounded).
  task automatic xfer(input logic [7:0] d, input logic s, input logic e, input logic er);
    bit got;
    int n;
    bus.snk_data_i  = d;
    bus.snk_sop_i   = s;
    bus.snk_eop_i   = e;
    bus.snk_err_i   = er;
    bus.snk_valid_i = 1'b1;
    got = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      got = bus.snk_ready_o;
      @(posedge clk);
      #1;
      n++;
    end while (!got && n < 2000);
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL handshake_timeout got ready=0 want ready=1 within 2000 cycles");
    end
  endtask

  task automatic idle(input int n);
    bus.snk_valid_i = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic strays(input int n);
    for (int i = 0; i < n; i++) xfer(8'($urandom_range(255)), 1'b0, 1'($urandom_range(1)), 1'b0);
    bus.snk_valid_i = 1'b0;
  endtask

  task automatic send_frame(input bq_t pl, input int under_at, input int err_at,
                            input int reset_at, input logic [1:0] g, input bit mid_sop);
    int  n;
    logic s;
    n = pl.size();
    push_frame(pl, (under_at >= 0) ? under_at : err_at, reset_at, g);
    for (int k = 0; k < n; k++) begin
      s = (k == 0) || (mid_sop && $urandom_range(15) == 0);
      if (k == reset_at) rst = 1'b1;
      xfer(pl[k], s, (k == n - 1), (k == err_at));
      if (k == reset_at) begin
        rst = 1'b0;
        checks++;
        if ({bus.gmii_tx_en_o, bus.gmii_tx_d_o, bus.gmii_tx_err_o, bus.frame_done_o,
             bus.frame_err_o} !== 12'h0 || sb.size() != 0) begin
          failures++;
          $display("FAIL reset_midframe got en=%b d=%h err=%b done=%b ferr=%b pending=%0d want all 0, pending=0",
                   bus.gmii_tx_en_o, bus.gmii_tx_d_o, bus.gmii_tx_err_o, bus.frame_done_o,
                   bus.frame_err_o, sb.size());
        end
      end
      if (k + 1 == under_at) begin
        bus.snk_valid_i = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    bus.snk_valid_i = 1'b0;
    bus.snk_sop_i   = 1'b0;
    bus.snk_eop_i   = 1'b0;
    bus.snk_err_i   = 1'b0;
  endtask

  // Pin monitor for the main instance.
  initial begin
    int   idle_cnt;
    bit   in_frame;
    exp_t e;
    idle_cnt = 1000;
    in_frame = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.gmii_tx_en_o) begin
        if (!in_frame && sb.size() > 0) begin
          if (sb[0].gap == G_EXACT) begin
            checks++;
            if (idle_cnt != IFG) begin
              failures++;
              $display("FAIL ifg_exact got %0d idle cycles want %0d", idle_cnt, IFG);
            end
          end else if (sb[0].gap == G_MIN) begin
            checks++;
            if (idle_cnt < IFG) begin
              failures++;
              $display("FAIL ifg_min got %0d idle cycles want >= %0d", idle_cnt, IFG);
            end
          end
        end
        in_frame = 1'b1;
        idle_cnt = 0;
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_pin_byte got d=%h err=%b want tx_en=0",
                   bus.gmii_tx_d_o, bus.gmii_tx_err_o);
        end else begin
          e = sb.pop_front();
          if ({bus.gmii_tx_d_o, bus.gmii_tx_err_o, bus.frame_done_o, bus.frame_err_o} !==
              {e.d, e.err, e.done, e.ferr}) begin
            failures++;
            $display("FAIL pin_byte got d=%h err=%b done=%b ferr=%b want d=%h err=%b done=%b ferr=%b",
                     bus.gmii_tx_d_o, bus.gmii_tx_err_o, bus.frame_done_o, bus.frame_err_o,
                     e.d, e.err, e.done, e.ferr);
          end
        end
      end else begin
        in_frame = 1'b0;
        idle_cnt++;
        checks++;
        if ({bus.gmii_tx_d_o, bus.gmii_tx_err_o, bus.frame_done_o, bus.frame_err_o} !== 11'h0) begin
          failures++;
          $display("FAIL idle_pins got d=%h err=%b done=%b ferr=%b want all 0",
                   bus.gmii_tx_d_o, bus.gmii_tx_err_o, bus.frame_done_o, bus.frame_err_o);
        end
      end
    end
  end

  // Collector for the no-padding instance.
  bq_t kq;
  int  kdone = 0;
  int  krise = 0;
  initial begin
    bit kin;
    kin = 1'b0;
    forever begin
      @(negedge clk);
      if (busk.gmii_tx_en_o) begin
        if (!kin) krise++;
        kin = 1'b1;
        kq.push_back(busk.gmii_tx_d_o);
        if (busk.frame_done_o) kdone++;
      end else begin
        kin = 1'b0;
      end
    end
  end

  initial begin
    bq_t  kexp;
    bit   got;
    int   n;
    int   len, kind, ua, ea, between;
    bit   prev_abort;
    logic [1:0] g;

    bus.snk_data_i = 8'h00;  bus.snk_valid_i = 1'b0; bus.snk_sop_i = 1'b0;
    bus.snk_eop_i = 1'b0;    bus.snk_err_i = 1'b0;
    busk.snk_data_i = 8'h00; busk.snk_valid_i = 1'b0; busk.snk_sop_i = 1'b0;
    busk.snk_eop_i = 1'b0;   busk.snk_err_i = 1'b0;
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if ({bus.gmii_tx_en_o, bus.gmii_tx_d_o, bus.gmii_tx_err_o, bus.frame_done_o,
         bus.frame_err_o, bus.snk_ready_o} !== 13'h0) begin
      failures++;
      $display("FAIL reset_outputs got en=%b d=%h err=%b done=%b ferr=%b rdy=%b want all 0",
               bus.gmii_tx_en_o, bus.gmii_tx_d_o, bus.gmii_tx_err_o, bus.frame_done_o,
               bus.frame_err_o, bus.snk_ready_o);
    end
    rst = 1'b0;

    // Known FCS on the unpadded instance.
    for (int k = 0; k < 9; k++) begin
      busk.snk_data_i  = 8'(8'h31 + k);
      busk.snk_sop_i   = (k == 0);
      busk.snk_eop_i   = (k == 8);
      busk.snk_valid_i = 1'b1;
      n = 0;
      do begin
        @(negedge clk);
        got = busk.snk_ready_o;
        @(posedge clk);
        #1;
        n++;
      end while (!got && n < 200);
      if (!got) begin
        checks++;
        failures++;
        $display("FAIL known_fcs_handshake got ready=0 want ready=1 within 200 cycles");
      end
    end
    busk.snk_valid_i = 1'b0;
    idle(40);
    kexp = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'hD5,
             8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
             8'h26, 8'h39, 8'hF4, 8'hCB};
    checks++;
    if (kq.size() != 21 || krise != 1 || kdone != 1) begin
      failures++;
      $display("FAIL known_fcs_shape got bytes=%0d bursts=%0d done=%0d want 21/1/1",
               kq.size(), krise, kdone);
    end
    for (int k = 0; k < 21 && k < kq.size(); k++) begin
      checks++;
      if (kq[k] !== kexp[k]) begin
        failures++;
        $display("FAIL known_fcs_byte%0d got %h want %h", k, kq[k], kexp[k]);
      end
    end

    // Directed cases on the padded instance.
    send_frame(rnd_payload(14), -1, -1, -1, G_MIN, 1'b0);    // padding
    send_frame(rnd_payload(64), -1, -1, -1, G_EXACT, 1'b0);  // back-to-back
    send_frame(rnd_payload(64), -1, -1, -1, G_EXACT, 1'b0);
    send_frame(rnd_payload(40), 20, -1, -1, G_EXACT, 1'b0);  // underrun
    send_frame(rnd_payload(50), -1, -1, -1, G_MIN, 1'b0);
    strays(3);
    send_frame(rnd_payload(30), -1, 29, -1, G_MIN, 1'b0);    // err with eop
    send_frame(rnd_payload(61), -1, -1, -1, G_EXACT, 1'b1);

    // Randomized frames, gaps, strays, aborts and mid-frame sop.
    prev_abort = 1'b0;
    for (int f = 0; f < 14; f++) begin
      len = $urandom_range(120, 1);
      kind = $urandom_range(9);
      between = $urandom_range(3);
      ua = -1;
      ea = -1;
      if (between == 2) idle($urandom_range(20, 1));
      else if (between == 3) strays($urandom_range(4, 1));
      g = (between >= 2 || prev_abort) ? G_MIN : G_EXACT;
      if (kind == 8 && len >= 2) ua = $urandom_range(len - 1, 1);
      else if (kind == 9) ea = $urandom_range(len - 1);
      send_frame(rnd_payload(len), ua, ea, -1, g, 1'b1);
      prev_abort = (ua >= 0) || (ea >= 0 && ea != len - 1);
    end

    // Reset during payload byte 10, then a clean frame.
    idle(30);
    send_frame(rnd_payload(40), -1, -1, 9, G_MIN, 1'b0);
    send_frame(rnd_payload(20), -1, -1, -1, G_NONE, 1'b0);

    idle(200);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
